// File: rtl/dest_pipe_tracker.sv
// Destination-register scoreboard for a 5-stage pipeline: tracks EXE/MEM/WB
// destination tags and write enables, and summarises them as a pending mask and count.
module dest_pipe_tracker #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TAG_W-1:0]    id_dest,
    input  logic                id_wb_en,
    input  logic                id_valid,
    input  logic                hazard_detected,
    input  logic                branch_flush,
    input  logic                freeze,
    output logic [TAG_W-1:0]    Exe_Dest,
    output logic                Exe_WB_En,
    output logic [TAG_W-1:0]    Mem_Dest,
    output logic                Mem_WB_En,
    output logic [TAG_W-1:0]    Wb_Dest,
    output logic                Wb_WB_En,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [1:0]          inflight_cnt
);

    typedef struct packed {
        logic [TAG_W-1:0] dest;
        logic             wb_en;
    } stage_t;

    stage_t exe_q, mem_q, wb_q;
    stage_t exe_d;
    logic   admit;

    // Non-writing or rejected instructions enter as a canonical {0,0} bubble.
    always_comb begin
        admit = id_valid & ~hazard_detected & ~branch_flush;
        exe_d = '0;
        if (admit && id_wb_en) begin
            exe_d.dest  = id_dest;
            exe_d.wb_en = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= exe_d;
        end
    end

    assign Exe_Dest  = exe_q.dest;
    assign Exe_WB_En = exe_q.wb_en;
    assign Mem_Dest  = mem_q.dest;
    assign Mem_WB_En = mem_q.wb_en;
    assign Wb_Dest   = wb_q.dest;
    assign Wb_WB_En  = wb_q.wb_en;

    // Tags beyond NUM_REGS match no bit, so they are counted but never masked.
    always_comb begin
        pending_mask = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (exe_q.wb_en && (32'(exe_q.dest) == r))
                            | (mem_q.wb_en && (32'(mem_q.dest) == r))
                            | (wb_q.wb_en  && (32'(wb_q.dest)  == r));
        end
    end

    assign inflight_cnt = 2'(exe_q.wb_en) + 2'(mem_q.wb_en) + 2'(wb_q.wb_en);

endmodule

// File: doc/dest_pipe_tracker.md
DEST_PIPE_TRACKER -- requirements
Module: dest_pipe_tracker

Interface
REQ-001 Parameter NUM_REGS, default 16, number of architectural registers tracked.
REQ-002 Parameter TAG_W, default 4, width of a register tag (log2 NUM_REGS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 id_dest  input  TAG_W  destination register of instruction in ID.
REQ-006 id_wb_en  input  1  ID instruction writes back.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 hazard_detected  input  1  hazard unit stall request; ID instruction must not advance.
REQ-009 branch_flush  input  1  taken branch; ID instruction is killed.
REQ-010 freeze  input  1  memory stall; whole tracker holds.
REQ-011 Exe_Dest / Exe_WB_En  output  TAG_W / 1  EXE-stage destination and write enable.
REQ-012 Mem_Dest / Mem_WB_En  output  TAG_W / 1  MEM-stage destination and write enable.
REQ-013 Wb_Dest / Wb_WB_En  output  TAG_W / 1  WB-stage destination and write enable.
REQ-014 pending_mask  output  NUM_REGS  bit r set while a write to register r is in flight.
REQ-015 inflight_cnt  output  2  count of stages with WB_En=1 (0..3).

Function
REQ-016 State: three stage registers EXE, MEM, WB, each {dest, wb_en}; all outputs derive from these registers only.
REQ-017 freeze=0 at clock edge: WB<=MEM, MEM<=EXE, EXE<=admit ? {id_dest, id_wb_en} : {0, 0}.
REQ-018 admit = id_valid & ~hazard_detected & ~branch_flush.
REQ-019 A bubble (not admitted) is {dest=0, wb_en=0}; older stages still advance that cycle.
REQ-020 An admitted instruction with id_wb_en=0 enters EXE with dest forced to 0.
REQ-021 freeze=1 at clock edge: EXE, MEM, WB all hold; hazard_detected, branch_flush, id_* ignored that cycle (freeze has priority; sources hold flush until unfrozen).
REQ-022 hazard_detected and branch_flush asserted together: bubble inserted, identical to either alone.
REQ-023 Latency: admitted ID instruction visible on Exe_* 1 cycle later, Mem_* 2, Wb_* 3 (unfrozen cycles); retires after the 4th edge.
REQ-024 pending_mask combinational from stage registers: bit r = OR over stages of (wb_en & dest==r); no extra cycle of latency.
REQ-025 Duplicate destinations in several stages: bit stays set until the last such stage retires.
REQ-026 Tag values >= NUM_REGS (only if NUM_REGS < 2**TAG_W) set no mask bit but still count in inflight_cnt.
REQ-027 inflight_cnt = Exe_WB_En + Mem_WB_En + Wb_WB_En; never exceeds 3, no wrap.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 rst=1 asynchronously clears all stages: every *_Dest=0, every *_WB_En=0, pending_mask=0, inflight_cnt=0, without waiting for clk.
REQ-030 rst asserted mid-operation discards all in-flight entries; first edge after release behaves per REQ-017 with empty pipeline.
REQ-031 Deassertion of rst takes effect on the next rising edge; no entry is admitted on the edge where rst is high.

Verification
REQ-032 Issue R3 wb_en=1 then 3 bubbles -> Exe_Dest=3 at cycle 1, Mem_Dest=3 at 2, Wb_Dest=3 at 3, pending_mask=0x0008 cycles 1-3, 0x0000 at 4.
REQ-033 Issue R5 with hazard_detected=1 -> Exe_WB_En=0, Exe_Dest=0, pending_mask unchanged by R5; MEM/WB still advance.
REQ-034 Pipeline holds R1/R2/R7 (EXE/MEM/WB), freeze=1 for 3 cycles with branch_flush pulsed -> all stages unchanged, pending_mask=0x0086, inflight_cnt=3; on release shifts normally.
REQ-035 Back-to-back R4, R4 -> pending_mask bit 4 set for 4 consecutive cycles, inflight_cnt 1,2,2,1,0.
REQ-036 Full pipeline, rst pulsed between clock edges -> all outputs 0 immediately; next admitted R9 appears on Exe_Dest one edge after rst release.
REQ-037 Admit id_wb_en=0 with id_dest=0xF -> Exe_Dest=0, Exe_WB_En=0, inflight_cnt unchanged.
